// File: rtl/run_sequencer.sv
// Run-length sequencer: counts enabled cycles from start up to a live terminal
// value, one-shot or wrapping, with mark comparators and a saturating wrap counter.

module run_sequencer_mark #(
  parameter int WIDTH = 32
) (
  input  logic             busy_i,
  input  logic [WIDTH-1:0] count_i,
  input  logic [WIDTH-1:0] mark_i,
  output logic             hit_o
);
  assign hit_o = busy_i && (count_i == mark_i);
endmodule

module run_sequencer #(
  parameter int WIDTH     = 32,
  parameter int NUM_MARKS = 2,
  parameter int WRAP_W    = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic                       en_i,
  input  logic                       mode_wrap_i,
  input  logic [WIDTH-1:0]           last_value_i,
  input  logic [NUM_MARKS*WIDTH-1:0] mark_value_i,
  output logic [WIDTH-1:0]           count_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       done_pulse_o,
  output logic [NUM_MARKS-1:0]       mark_hit_o,
  output logic [NUM_MARKS-1:0]       mark_seen_o,
  output logic [WRAP_W-1:0]          wrap_count_o
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [WIDTH-1:0]     count_q, count_d;
  logic [WRAP_W-1:0]    wrap_q, wrap_d;
  logic [NUM_MARKS-1:0] seen_q, seen_d;
  logic                 pulse_q, pulse_d;
  logic                 mode_q, mode_d;
  logic [NUM_MARKS-1:0] hit;

  assign busy_o = (state_q == S_RUN);
  assign done_o = (state_q == S_DONE);

  for (genvar i = 0; i < NUM_MARKS; i++) begin : g_mark
    run_sequencer_mark #(.WIDTH(WIDTH)) u_mark (
      .busy_i  (busy_o),
      .count_i (count_q),
      .mark_i  (mark_value_i[i*WIDTH +: WIDTH]),
      .hit_o   (hit[i])
    );
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wrap_d  = wrap_q;
    seen_d  = seen_q;
    mode_d  = mode_q;
    pulse_d = 1'b0;
    if (abort_i) begin
      state_d = S_IDLE;
      count_d = '0;
    end else if (start_i) begin
      state_d = S_RUN;
      count_d = '0;
      wrap_d  = '0;
      seen_d  = '0;
      mode_d  = mode_wrap_i;
    end else if (state_q == S_RUN) begin
      // Marks latch on stall cycles too, since hit is independent of en.
      seen_d = seen_q | hit;
      if (en_i) begin
        // >= lets a lowered last_value end the run on the next enabled cycle.
        if (count_q >= last_value_i) begin
          pulse_d = 1'b1;
          if (mode_q) begin
            count_d = '0;
            if (wrap_q != {WRAP_W{1'b1}}) wrap_d = wrap_q + WRAP_W'(1);
          end else begin
            state_d = S_DONE;
          end
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      count_q <= '0;
      wrap_q  <= '0;
      seen_q  <= '0;
      pulse_q <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      seen_q  <= seen_d;
      pulse_q <= pulse_d;
      mode_q  <= mode_d;
    end
  end

  assign count_o      = count_q;
  assign done_pulse_o = pulse_q;
  assign mark_hit_o   = hit;
  assign mark_seen_o  = seen_q;
  assign wrap_count_o = wrap_q;
endmodule

// File: tb/tb_run_sequencer.sv
// Randomised and directed scoreboard bench for run_sequencer against a
// behavioural model of runs, wraps and marks.

module tb_run_sequencer;
  localparam int W  = 32;
  localparam int NM = 2;
  localparam int WW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          r_rst = 1'b0, r_start = 1'b0, r_abort = 1'b0, r_en = 1'b0, r_mode = 1'b0;
  logic [W-1:0]  r_last = '0;
  logic [W-1:0]  r_mark [NM];
  logic [NM*W-1:0] mark_bus;
  logic [W-1:0]  count;
  logic          busy, done, done_pulse;
  logic [NM-1:0] mark_hit, mark_seen;
  logic [WW-1:0] wrap_count;

  assign mark_bus = {r_mark[1], r_mark[0]};

  run_sequencer #(.WIDTH(W), .NUM_MARKS(NM), .WRAP_W(WW)) dut (
    .clk_i(clk), .reset_i(r_rst), .start_i(r_start), .abort_i(r_abort),
    .en_i(r_en), .mode_wrap_i(r_mode), .last_value_i(r_last),
    .mark_value_i(mark_bus), .count_o(count), .busy_o(busy), .done_o(done),
    .done_pulse_o(done_pulse), .mark_hit_o(mark_hit), .mark_seen_o(mark_seen),
    .wrap_count_o(wrap_count)
  );

  typedef struct {
    logic [W-1:0]  cnt;
    logic          busy, done, pulse;
    logic [NM-1:0] hit, seen;
    logic [WW-1:0] wrap;
  } snap_t;
  typedef struct {
    logic [W-1:0]  cnt;
    logic [WW-1:0] wrap;
  } ev_t;

  snap_t snap_q[$];
  ev_t   ev_q[$];
  int    n_chk = 0, n_err = 0;

  // Behavioural model: a run is "active" or "finished"; count, wraps and seen marks.
  logic          m_active = 0, m_fin = 0, m_pulse = 0, m_mode = 0, m_valid = 0;
  logic [W-1:0]  m_cnt = '0;
  int            m_wraps = 0;
  logic [NM-1:0] m_seen = '0;

  function automatic logic [NM-1:0] exp_hit();
    logic [NM-1:0] h = '0;
    for (int i = 0; i < NM; i++) h[i] = m_active && (m_cnt == r_mark[i]);
    return h;
  endfunction

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  task automatic model_step();
    logic [NM-1:0] h;
    ev_t e;
    h = exp_hit();
    m_pulse = 0;
    if (!r_rst) begin
      m_active = 0; m_fin = 0; m_cnt = '0; m_wraps = 0; m_seen = '0; m_mode = 0;
    end else if (r_abort) begin
      m_active = 0; m_fin = 0; m_cnt = '0;
    end else if (r_start) begin
      m_active = 1; m_fin = 0; m_cnt = '0; m_wraps = 0; m_seen = '0; m_mode = r_mode;
    end else if (m_active) begin
      m_seen = m_seen | h;
      if (r_en) begin
        if (m_cnt >= r_last) begin
          m_pulse = 1;
          if (m_mode) begin
            m_cnt = '0;
            m_wraps = (m_wraps + 1 > 3) ? 3 : m_wraps + 1;
          end else begin
            m_active = 0; m_fin = 1;
          end
          e.cnt = m_cnt; e.wrap = WW'(m_wraps);
          ev_q.push_back(e);
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
    m_valid = 1;
  endtask

  // Inputs are already set for this cycle; publish the expected view, then clock.
  task automatic cyc();
    snap_t s;
    if (m_valid) begin
      s.cnt = m_cnt; s.busy = m_active; s.done = m_fin; s.pulse = m_pulse;
      s.hit = exp_hit(); s.seen = m_seen; s.wrap = WW'(m_wraps);
      snap_q.push_back(s);
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drv(input logic rst, input logic st, input logic ab, input logic en);
    r_rst = rst; r_start = st; r_abort = ab; r_en = en;
    cyc();
  endtask

  task automatic run_to(input logic [W-1:0] target);
    int guard = 0;
    while (m_cnt != target && guard < 500) begin
      drv(1, 0, 0, 1);
      guard++;
    end
    if (guard >= 500) begin
      n_chk++; n_err++;
      $display("FAIL run_to: count %0d never reached %0d", m_cnt, target);
    end
  endtask

  always @(negedge clk) begin
    snap_t s;
    ev_t e;
    if (snap_q.size() > 0) begin
      s = snap_q.pop_front();
      chk("count", 64'(count), 64'(s.cnt));
      chk("busy", 64'(busy), 64'(s.busy));
      chk("done", 64'(done), 64'(s.done));
      chk("done_pulse", 64'(done_pulse), 64'(s.pulse));
      chk("mark_hit", 64'(mark_hit), 64'(s.hit));
      chk("mark_seen", 64'(mark_seen), 64'(s.seen));
      chk("wrap_count", 64'(wrap_count), 64'(s.wrap));
    end
    if (done_pulse === 1'b1) begin
      if (ev_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL terminal_event: unexpected done_pulse at t=%0t", $time);
      end else begin
        e = ev_q.pop_front();
        chk("event_count", 64'(count), 64'(e.cnt));
        chk("event_wrap", 64'(wrap_count), 64'(e.wrap));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    r_mark[0] = '0; r_mark[1] = '0;
    #1;
    repeat (3) drv(0, 0, 0, 0);
    drv(1, 0, 0, 0);

    // One-shot 0..99 with one reachable and one unreachable mark
    r_last = 99; r_mode = 0; r_mark[0] = 30; r_mark[1] = 300;
    drv(1, 1, 0, 0);
    repeat (103) drv(1, 0, 0, 1);

    // Wrap mode with saturating wrap counter
    r_last = 3; r_mode = 1; r_mark[0] = 2; r_mark[1] = 2;
    drv(1, 1, 0, 0);
    repeat (40) drv(1, 0, 0, 1);

    // Stall at 4, then lower terminal below count at 7
    r_last = 10; r_mode = 0; r_mark[0] = 4; r_mark[1] = 9;
    drv(1, 1, 0, 0);
    run_to(4);
    repeat (5) drv(1, 0, 0, 0);
    run_to(7);
    r_last = 2;
    repeat (3) drv(1, 0, 0, 1);

    // start and abort together, then restart mid-run
    r_last = 99; r_mark[0] = 10; r_mark[1] = 60;
    drv(1, 1, 0, 0);
    run_to(20);
    drv(1, 1, 1, 1);
    drv(1, 0, 0, 1);
    drv(1, 1, 0, 0);
    run_to(50);
    drv(1, 1, 0, 1);
    repeat (3) drv(1, 0, 0, 1);

    // Reset overriding start mid-run, then idle after release
    run_to(20);
    drv(0, 1, 0, 1);
    repeat (4) drv(1, 0, 0, 1);

    // Terminal value 0 with a mark at 0
    r_last = 0; r_mark[0] = 0; r_mark[1] = 5;
    drv(1, 1, 0, 0);
    repeat (3) drv(1, 0, 0, 1);

    // Randomised traffic on small ranges so terminals and marks recur
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 49) == 0) r_last = $urandom_range(0, 12);
      if ($urandom_range(0, 39) == 0) r_mark[$urandom_range(0, 1)] = $urandom_range(0, 14);
      r_mode = $urandom_range(0, 1);
      drv($urandom_range(0, 199) != 0, $urandom_range(0, 29) == 0,
          $urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0);
    end

    repeat (3) drv(1, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("pending_events", 64'(ev_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
